fifo_destino: RTL and testbench

FIFO_DESTINO -- requirements
Module: fifo_destino

---
 rtl/fifo_destino_pkg.sv | 15 +
 rtl/fifo_destino_memoria_dp.sv | 29 ++
 rtl/fifo_destino.sv | 105 ++++++++++
 tb/tb_fifo_destino.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_destino_pkg.sv
// Shared router definitions: FIFO geometry defaults and the position of the
// destination field inside a word, used by the FIFO and the arbiter.
package fifo_destino_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int DEPTH_DEF      = 8;
  localparam int AF_THRESH_DEF  = 6;
  localparam int AE_THRESH_DEF  = 1;

  // Destination field occupies the two most significant bits of a word.
  localparam int DEST_W   = 2;
  localparam int DEST_MSB = DATA_WIDTH_DEF - 1;
  localparam int DEST_LSB = DATA_WIDTH_DEF - DEST_W;

endpackage

// File: rtl/fifo_destino_memoria_dp.sv
// Storage for fifo_destino: DEPTH x DATA_WIDTH register file with one
// synchronous write port and one combinational (fall-through) read port.
// Contents are deliberately not reset.
module memoria_dp #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store wdata on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: combinational so the head word is visible without a pop.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/fifo_destino.sv
// Destination FIFO feeding the router arbiter. First-word-fall-through:
// the head word and its destination field are always presented; the arbiter
// retires it by raising pop. Pointers, occupancy and flags live here, storage
// lives in memoria_dp.
//
// Handshake: push/pop are sampled on each rising edge. A pop retires the head
// only when the FIFO is non-empty; a push is accepted when the FIFO is not full
// or when a pop retires a word in the same cycle (pop evaluated first). A pop
// on empty or a push on full without pop sets the sticky error flag. Operations
// presented on the first edge after reset release are ignored.
module fifo_destino
  import fifo_destino_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AF_THRESH  = AF_THRESH_DEF,
  parameter int AE_THRESH  = AE_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DEST_W-1:0]     dest,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  active;
  logic                  do_push;
  logic                  do_pop;
  logic                  err_evt;
  logic [DATA_WIDTH-1:0] rd_data;

  memoria_dp #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (do_push),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  // Flags decoded straight from the occupancy register.
  always_comb begin
    fifo_empty   = (count == '0);
    fifo_full    = (count == FULL_C);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
  end

  // Accept/reject decision: pop first, so a full FIFO can push while popping.
  always_comb begin
    do_pop  = active && pop && !fifo_empty;
    do_push = active && push && (!fifo_full || do_pop);
    err_evt = active && ((pop && fifo_empty) || (push && fifo_full && !pop));
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointer, occupancy and sticky error state; `active` masks the first edge
  // after reset release so a request overlapping the release is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      error  <= 1'b0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      count  <= count_next;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (err_evt) error  <= 1'b1;
    end
  end

  // Head word and its destination; forced to zero while empty.
  always_comb begin
    data_out = fifo_empty ? '0 : rd_data;
    dest     = data_out[DATA_WIDTH-1 -: DEST_W];
  end

endmodule

// File: tb/tb_fifo_destino.sv
// Self-checking bench for fifo_destino: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_fifo_destino;

  localparam int DW    = 6;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  // clock / reset / DUT signals
  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [1:0]    dest;
  logic          fifo_empty;
  logic          fifo_full;
  logic          almost_full;
  logic          almost_empty;
  logic          error;

  fifo_destino #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .dest        (dest),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: stored words in order, sticky error, and a flag that
  // swallows the first edge after reset release
  logic [DW-1:0] exp_q[$];
  bit            m_err;
  bit            m_skip;

  int n_chk;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] head;
    logic [DW-1:0] hd;
    int n;
    n    = exp_q.size();
    head = (n > 0) ? exp_q[0] : '0;
    hd   = head;
    check({tag, ".dout"},  32'(data_out),     32'(head));
    check({tag, ".dest"},  32'(dest),         32'(hd[DW-1 -: 2]));
    check({tag, ".empty"}, 32'(fifo_empty),   32'(n == 0));
    check({tag, ".full"},  32'(fifo_full),    32'(n == DEPTH));
    check({tag, ".af"},    32'(almost_full),  32'(n >= AF));
    check({tag, ".ae"},    32'(almost_empty), 32'(n <= AE));
    check({tag, ".err"},   32'(error),        32'(m_err));
  endtask

  // driver: present one request for one clock edge, update model, check
  task automatic step(input bit pu, input bit po, input logic [DW-1:0] d, input string tag);
    push    = pu;
    pop     = po;
    data_in = d;
    if (m_skip) begin
      m_skip = 1'b0;
    end else begin
      if (po) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else m_err = 1'b1;
      end
      if (pu) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    check_all(tag);
  endtask

  // assert reset now (asynchronously), check reset outputs, release at negedge
  task automatic hard_reset(input string tag, input bit idle_after);
    reset = 1'b1;
    #1;
    exp_q.delete();
    m_err = 1'b0;
    check_all(tag);
    @(negedge clk);
    reset  = 1'b0;
    m_skip = 1'b1;
    if (idle_after) step(1'b0, 1'b0, '0, {tag, ".rel"});
  endtask

  logic [DW-1:0] w;

  initial begin
    n_chk   = 0;
    n_bad   = 0;
    m_err   = 1'b0;
    m_skip  = 1'b0;
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;

    // reset state
    #2;
    check_all("rst0");
    @(negedge clk);
    reset  = 1'b0;
    m_skip = 1'b1;
    step(1'b0, 1'b0, '0, "rel0");

    // single push of 0x25: head visible, dest 2'b10, almost_empty still 1
    step(1'b1, 1'b0, 6'h25, "push25");
    check("push25.dest_lit", 32'(dest), 32'h2);

    // fill to full, then an overflowing push is dropped
    hard_reset("rst1", 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 6'($urandom_range(0, 63)), "fill");
    check("fill.full_lit", 32'(fifo_full), 32'h1);
    step(1'b1, 1'b0, 6'h3F, "ovf");
    check("ovf.err_lit", 32'(error), 32'h1);

    // full with simultaneous push+pop: count stays 8, new word goes to slot 0
    hard_reset("rst2", 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 6'(i + 8), "fill2");
    step(1'b1, 1'b1, 6'h2A, "fullpp");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, "drain2");

    // pop on empty, then push+pop on empty
    hard_reset("rst3", 1'b1);
    step(1'b0, 1'b1, '0, "popempty");
    step(1'b1, 1'b0, 6'h15, "afterpe");
    step(1'b0, 1'b1, '0, "drain3");
    step(1'b1, 1'b1, 6'h31, "ppempty");

    // 20 alternating push/pop cycles, pointers wrap several times
    hard_reset("rst4", 1'b1);
    for (int i = 0; i < 20; i++) begin
      w = 6'($urandom_range(0, 63));
      step(1'b1, 1'b0, w, "altpush");
      step(1'b0, 1'b1, '0, "altpop");
    end

    // mid-cycle reset with 5 stored words; request at release is ignored
    hard_reset("rst5", 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'($urandom_range(0, 63)), "fill5");
    #3;
    hard_reset("rstmid", 1'b0);
    step(1'b1, 1'b0, 6'h3A, "relpush");
    step(1'b1, 1'b0, 6'h2B, "entry0");

    // random traffic with varying push/pop bias
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      step(bit'($urandom_range(0, 99) < bias), bit'($urandom_range(0, 99) < 100 - bias),
           6'($urandom_range(0, 63)), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
